xor_stream_unit: RTL

Parametrised, registered successor to the combinational two-input XOR gate. It accepts WIDTH-bit operand pairs over a valid/ready stream and applies one of four per-beat modes: bitwise XOR, reduction parity, frame-accumulated XOR checksum, or bitwise XNOR. Results leave through a single-stage output register with backpressure. The block sits in the digit-circuit datapath library as the building block for checksum and parity generation.

---
 rtl/xor_stream_unit_pkg.sv | 17 +
 rtl/xor_stream_unit_if.sv | 33 +++
 rtl/xor_core.sv | 32 +++
 rtl/xor_stream_unit.sv | 71 +++++++
 4 files changed

// File: rtl/xor_stream_unit_pkg.sv
// Shared mode and state encodings for the xor stream unit.
// Imported by the interface, the core and the top.
package xor_stream_unit_pkg;

  typedef enum logic [1:0] {
    MODE_XOR    = 2'd0,
    MODE_PARITY = 2'd1,
    MODE_ACCUM  = 2'd2,
    MODE_XNOR   = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } state_e;

endpackage

// File: rtl/xor_stream_unit_if.sv
// Operand/result stream bundle for the xor stream unit.
// slave = block side, master = producer/consumer side.
interface xor_stream_unit_if #(
  parameter int WIDTH = 8
);
  import xor_stream_unit_pkg::*;

  logic             in_valid;
  logic             in_ready;
  mode_e            in_mode;
  logic             in_last;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  mode_e            out_mode;

  modport slave (
    input  in_valid, in_mode, in_last,
    input  in_a, in_b, out_ready,
    output in_ready, out_valid,
    output out_y, out_mode
  );

  modport master (
    output in_valid, in_mode, in_last,
    output in_a, in_b, out_ready,
    input  in_ready, out_valid,
    input  out_y, out_mode
  );

endinterface

// File: rtl/xor_core.sv
// Combinational per-beat result for one lane.
// ACCUM yields acc ^ a ^ b, which is also the next acc value.
module xor_core
  import xor_stream_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  mode_e            mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] acc_i,
  output logic [WIDTH-1:0] y_o
);

  logic [WIDTH-1:0] ab;

  assign ab = a_i ^ b_i;

  always_comb begin
    y_o = ab;
    unique case (mode_i)
      MODE_XOR:    y_o = ab;
      MODE_PARITY: begin
        y_o    = '0;
        y_o[0] = ^ab;
      end
      MODE_ACCUM:  y_o = acc_i ^ ab;
      MODE_XNOR:   y_o = ~ab;
    endcase
  end

endmodule

// File: rtl/xor_stream_unit.sv
// Registered xor/parity/checksum/xnor stream unit with
// a single-stage backpressured output register.
module xor_stream_unit
  import xor_stream_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  xor_stream_unit_if.slave s,
  output logic             busy
);

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_y_q;
  mode_e            out_mode_q;

  logic [WIDTH-1:0] res_d;
  logic             accept;
  logic             is_accum;
  logic             produce;

  xor_core #(.WIDTH(WIDTH)) u_core (
    .mode_i (s.in_mode),
    .a_i    (s.in_a),
    .b_i    (s.in_b),
    .acc_i  (acc_q),
    .y_o    (res_d)
  );

  assign s.in_ready = !rst && (!out_valid_q || s.out_ready);
  assign accept     = s.in_valid && s.in_ready;
  assign is_accum   = (s.in_mode == MODE_ACCUM);
  assign produce    = accept && (!is_accum || s.in_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_mode_q  <= MODE_XOR;
    end else begin
      if (produce) begin
        out_valid_q <= 1'b1;
        out_y_q     <= res_d;
        out_mode_q  <= s.in_mode;
      end else if (s.out_ready) begin
        out_valid_q <= 1'b0;
      end
      // Non-ACCUM beats leave the open frame untouched
      if (accept && is_accum) begin
        if (s.in_last) begin
          acc_q   <= '0;
          state_q <= ST_IDLE;
        end else begin
          acc_q   <= res_d;
          state_q <= ST_FRAME;
        end
      end
    end
  end

  assign s.out_valid = out_valid_q;
  assign s.out_y     = out_y_q;
  assign s.out_mode  = out_mode_q;
  assign busy        = (state_q == ST_FRAME);

endmodule
